instr_loader: RTL
=================

Name: instr_loader

Overview:
- Boot-time program loader sitting directly upstream of the instruction memory write port (enable / address / data_in).
- Consumes a byte stream from the serial receiver, assembles little-endian 32-bit instruction words and writes them one word per write cycle.
- Holds the core in reset until a complete image has been written.

Parameters:
- ADDR_W, 8, instruction memory word-address width.
- DEPTH, 256, number of words in instruction memory; maximum legal image length.
- TIMEOUT_CYCLES, 1000000, maximum idle cycles between accepted bytes while loading; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load; honoured in IDLE, DONE and ERROR only.
- byte_valid  in  1  byte_data is valid this cycle.
- byte_data  in  8  received byte.
- byte_ready  out  1  loader can accept a byte this cycle.
- mem_enable  out  1  instruction memory write enable.
- mem_address  out  ADDR_W  instruction memory word address.
- mem_data  out  32  instruction word to write.
- cpu_hold  out  1  high keeps the core in reset.
- load_done  out  1  image loaded successfully.
- load_error  out  1  load aborted.

Behaviour:
- Reset values:
  - State IDLE.
  - All counters and the word buffer 0.
  - byte_ready=0, mem_enable=0, mem_address=0, mem_data=0.
  - cpu_hold=1, load_done=0, load_error=0.
- Handshake: a byte is accepted on a rising edge where byte_valid && byte_ready. byte_ready is a registered function of state: 1 in LEN_LO, LEN_HI, DATA and CHECK; 0 elsewhere.
- Stream format:
  - Word count N is sent as 16-bit little-endian: LEN_LO byte, then LEN_HI byte.
  - Then N*4 payload bytes; each word is sent least-significant byte first.
- State transitions:
  - IDLE: start -> LEN_LO. Clears load_done, load_error, the word index and the byte counter. cpu_hold stays 1.
  - LEN_LO: on accept, latch the low byte -> LEN_HI.
  - LEN_HI: on accept, form N. If N==0 or N>DEPTH -> ERROR; else -> DATA.
  - DATA: each accepted byte is shifted into the word buffer at position byte_cnt (0..3). The 4th byte -> WRITE.
  - WRITE: one cycle only, with mem_enable=1, mem_address=word index, mem_data=assembled word. Then increment the word index. If index+1==N -> CHECK (CHECKSUM_EN) or DONE; else -> DATA.
  - DONE: load_done=1, cpu_hold=0. start -> LEN_LO (cpu_hold=1 again, load_done=0).
  - ERROR: load_error=1, cpu_hold=1. start -> LEN_LO (load_error cleared).
- Write timing: if the 4th byte of word k is accepted at edge t, mem_enable is high in the cycle after t with address k. The memory captures the word at edge t+1.
- mem_enable is never high for two consecutive cycles.
- mem_address and mem_data hold their last values when mem_enable=0.
- Timeout:
  - A counter runs in LEN_LO, LEN_HI, DATA and CHECK; it clears on every accepted byte and on state entry.
  - Reaching TIMEOUT_CYCLES -> ERROR. A byte accepted in the same cycle takes priority and clears the counter.
- start in any loading state is ignored.
- rst asserted mid-load returns immediately to reset values. Words already written stay in memory; cpu_hold remains 1.
- Word index width is ADDR_W+1, so N=DEPTH completes without wrap. Word index DEPTH-1 is the last address written.

Optional Feature:
- CHECKSUM_EN defined:
  - A running 8-bit XOR of all payload bytes is kept.
  - After the last WRITE, state CHECK accepts one more byte.
  - Byte equal to the XOR -> DONE; otherwise -> ERROR.
  - Timeout applies in CHECK.
- Not defined: CHECK state and XOR logic are absent; the last WRITE goes directly to DONE.

Test Plan:
- Reset then idle: no start for 100 cycles -> cpu_hold=1, byte_ready=0, mem_enable never high.
- start, stream 02 00 13 00 00 00 B3 80 20 00 -> writes addr0=0x00000013, addr1=0x002080B3, each with a single-cycle mem_enable. Then load_done=1, cpu_hold=0. With CHECKSUM_EN, append 0x00 to reach DONE.
- Length 00 00, and separately 01 01 (N=257) -> load_error=1, no write, cpu_hold=1. A following start plus a valid image -> DONE.
- N=256 full image of incrementing words 0..255 -> final write at address 255 with data 0x000000FF, then DONE, no address wrap.
- TIMEOUT_CYCLES=50: stop after 2 payload bytes -> ERROR exactly 50 cycles after the last accepted byte. Gaps of 49 cycles between bytes -> no error.
- CHECKSUM_EN: image 01 00 11 22 33 44 followed by 0x44 -> DONE; followed by 0x45 -> ERROR, cpu_hold=1.
- rst pulsed during the 3rd data byte -> outputs return to reset values, state IDLE.

Source files
------------

// File: rtl/instr_loader.sv
// instr_loader: boot-time program loader feeding the instruction memory
// write port. Takes a little-endian 16-bit word count followed by the
// payload bytes, assembles 32-bit words LSB first and writes one word per
// write cycle. The core is held in reset until a full image has landed.
//
// Optional feature macro: CHECKSUM_EN
//   defined   -> an 8-bit XOR of all payload bytes must match one trailing
//                byte (state CHECK) before the load is declared done.
//   undefined -> the last write goes straight to DONE.

module instr_loader #(
    parameter int ADDR_W         = 8,
    parameter int DEPTH          = 256,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    output logic              mem_enable_o,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic [31:0]       mem_data_o,
    output logic              cpu_hold_o,
    output logic              load_done_o,
    output logic              load_error_o
);

    // Word index is one bit wider than the address so an image of exactly
    // DEPTH words can finish without the index wrapping to zero.
    localparam int IDX_W = ADDR_W + 1;

    // Idle counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST =
        TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
`ifdef CHECKSUM_EN
        S_CHECK  = 3'd5,
`endif
        S_DONE   = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         len_lo_q;
    logic [15:0]        len_q;
    logic [15:0]        len_d;
    logic [IDX_W-1:0]   word_idx_q;
    logic [1:0]         byte_cnt_q;
    logic [31:0]        word_q, word_d;
    logic [TO_W-1:0]    to_cnt_q;
    logic               byte_ready_q;
    logic               mem_enable_q;
    logic [ADDR_W-1:0]  mem_address_q;
    logic [31:0]        mem_data_q;
    logic               cpu_hold_q;
    logic               load_done_q;
    logic               load_error_q;
`ifdef CHECKSUM_EN
    logic [7:0]         xor_q;
    logic [7:0]         xor_d;
`endif

    logic accept;
    logic start_ok;
    logic len_bad;
    logic last_word;
    logic timeout_hit;

    // States in which a byte may be accepted (and the idle timer runs).
    function automatic logic is_loading(input state_t s);
        is_loading = (s == S_LEN_LO) || (s == S_LEN_HI) || (s == S_DATA)
`ifdef CHECKSUM_EN
                     || (s == S_CHECK)
`endif
                     ;
    endfunction

    assign accept    = byte_valid_i && byte_ready_q;
    assign start_ok  = start_i && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                                   (state_q == S_ERROR));
    assign len_d     = {byte_data_i, len_lo_q};
    assign len_bad   = (len_d == 16'd0) || (32'(len_d) > 32'(DEPTH));
    assign last_word = ((32'(word_idx_q) + 32'd1) == 32'(len_q));
    // An accepted byte in the same cycle wins over the timeout.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && byte_ready_q && !accept &&
                         (to_cnt_q == TO_LAST);
`ifdef CHECKSUM_EN
    assign xor_d = xor_q ^ byte_data_i;
`endif

    // Insert the incoming byte into the word buffer at the current byte slot.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        word_d = word_q;
        case (byte_cnt_q)
            2'd0:    word_d[7:0]   = byte_data_i;
            2'd1:    word_d[15:8]  = byte_data_i;
            2'd2:    word_d[23:16] = byte_data_i;
            default: word_d[31:24] = byte_data_i;
        endcase
    end

    // Next-state selection for the load sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_i) state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (accept)           state_d = S_LEN_HI;
                else if (timeout_hit) state_d = S_ERROR;
            end
            S_LEN_HI: begin
                if (accept)           state_d = len_bad ? S_ERROR : S_DATA;
                else if (timeout_hit) state_d = S_ERROR;
            end
            S_DATA: begin
                if (accept) begin
                    if (byte_cnt_q == 2'd3) state_d = S_WRITE;
                end else if (timeout_hit) begin
                    state_d = S_ERROR;
                end
            end
            S_WRITE: begin
`ifdef CHECKSUM_EN
                state_d = last_word ? S_CHECK : S_DATA;
`else
                state_d = last_word ? S_DONE : S_DATA;
`endif
            end
`ifdef CHECKSUM_EN
            S_CHECK: begin
                if (accept)           state_d = (byte_data_i == xor_q) ? S_DONE : S_ERROR;
                else if (timeout_hit) state_d = S_ERROR;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the word buffer is a handful of flops, not a RAM, so it
            // is reset along with everything else to give a known image.
            state_q       <= S_IDLE;
            len_lo_q      <= '0;
            len_q         <= '0;
            word_idx_q    <= '0;
            byte_cnt_q    <= '0;
            word_q        <= '0;
            to_cnt_q      <= '0;
            byte_ready_q  <= 1'b0;
            mem_enable_q  <= 1'b0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            cpu_hold_q    <= 1'b1;
            load_done_q   <= 1'b0;
            load_error_q  <= 1'b0;
`ifdef CHECKSUM_EN
            xor_q         <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q      <= state_d;
            byte_ready_q <= is_loading(state_d);
            mem_enable_q <= (state_d == S_WRITE);

            if (start_ok) begin
                word_idx_q   <= '0;
                byte_cnt_q   <= '0;
                load_done_q  <= 1'b0;
                load_error_q <= 1'b0;
                cpu_hold_q   <= 1'b1;
`ifdef CHECKSUM_EN
                xor_q        <= '0;
`endif
            end

            if (state_q == S_LEN_LO && accept) len_lo_q <= byte_data_i;
            if (state_q == S_LEN_HI && accept) len_q    <= len_d;

            if (state_q == S_DATA && accept) begin
                word_q     <= word_d;
                byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef CHECKSUM_EN
                xor_q      <= xor_d;
`endif
                if (byte_cnt_q == 2'd3) begin
                    mem_address_q <= word_idx_q[ADDR_W-1:0];
                    mem_data_q    <= word_d;
                end
            end

            if (state_q == S_WRITE) word_idx_q <= word_idx_q + IDX_W'(1);

            if (state_d == S_DONE && state_q != S_DONE) begin
                load_done_q <= 1'b1;
                cpu_hold_q  <= 1'b0;
            end
            if (state_d == S_ERROR && state_q != S_ERROR) begin
                load_error_q <= 1'b1;
                cpu_hold_q   <= 1'b1;
            end

            // Idle timer: cleared on accept, on state change and outside loading.
            if (TIMEOUT_CYCLES == 0 || accept || state_d != state_q || !byte_ready_q)
                to_cnt_q <= '0;
            else
                to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

    assign byte_ready_o  = byte_ready_q;
    assign mem_enable_o  = mem_enable_q;
    assign mem_address_o = mem_address_q;
    assign mem_data_o    = mem_data_q;
    assign cpu_hold_o    = cpu_hold_q;
    assign load_done_o   = load_done_q;
    assign load_error_o  = load_error_q;

endmodule
